// File: rtl/impl_riscv_gnt_stall.sv
// Grant-side stall generator for the OBI memory model: delays gnt_o by a fixed or
// LFSR-derived number of cycles and caps granted-but-unresponded transactions.
module impl_riscv_gnt_stall #(
    parameter int          DELAY_WL        = 4,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        rvalid_i,
    input  logic        en_stall_i,
    input  logic [31:0] stall_mode_i,
    input  logic [31:0] max_stall_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t              state;
    logic [DELAY_WL-1:0] cnt;
    logic [CW-1:0]       outstanding;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [DELAY_WL-1:0] max_d;
    logic [DELAY_WL-1:0] rnd_d;
    logic [DELAY_WL-1:0] delay;
    logic                full;
    logic                dec;

    assign max_d = max_stall_i[DELAY_WL-1:0];
    assign rnd_d = lfsr[DELAY_WL-1:0];
    assign full  = (outstanding == CW'(MAX_OUTSTANDING));
    assign dec   = rvalid_i && (outstanding != '0);

    // Right-shifting Galois form of x^16+x^14+x^13+x^11.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        delay = '0;
        if (en_stall_i) begin
            if (stall_mode_i == 32'd1) begin
                delay = max_d;
            end else if (stall_mode_i == 32'd2) begin
                delay = (rnd_d > max_d) ? max_d : rnd_d;
            end
        end
    end

    always_comb begin
        gnt_o = 1'b0;
        if (req_i && !full) begin
            if (state == IDLE) begin
                gnt_o = (delay == '0);
            end else begin
                gnt_o = (cnt == '0);
            end
        end
    end

    assign mem_req_o   = req_i && gnt_o;
    assign mem_we_o    = we_i;
    assign mem_be_o    = be_i;
    assign mem_addr_o  = addr_i;
    assign mem_wdata_o = wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            outstanding <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && !gnt_o) begin
                        cnt   <= (delay == '0) ? '0 : delay - DELAY_WL'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DELAY_WL'(1);
                    end else if (!full) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (mem_req_o) begin
                lfsr <= lfsr_next;
            end

            if (mem_req_o && !dec) begin
                outstanding <= outstanding + CW'(1);
            end else if (!mem_req_o && dec) begin
                outstanding <= outstanding - CW'(1);
            end
        end
    end

endmodule
